memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//  Shares one external memory bus between the instruction-fetch and data-memory request paths.
//  - Sits between the request unit and the memory controller.
//  - Serialises imem reads and dmem reads/writes: one outstanding bus transaction at a time.
//  - Returns a one-cycle ready pulse plus registered load data to the winning requester.
//  - Data requests have priority over fetch (older instruction in the pipeline).
// PARAMETERS
//  ADDR_W       32   address width
//  DATA_W       32   data width (word_t)
//  TIMEOUT_CYC  255  bus cycles before abort; used only with MEM_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1        clock, rising edge
//  nRst       in   1        reset, asynchronous, active-low
//  imemRen    in   1        fetch request; held until i_ready
//  imemaddr   in   ADDR_W   fetch address
//  dmmRen     in   1        data read request; held until d_ready
//  dmmWen     in   1        data write request; held until d_ready
//  dmmaddr    in   ADDR_W   data address
//  dmmstore   in   DATA_W   store data
//  dmmsel     in   4        byte enables for the data access
//  i_ready    out  1        one-cycle pulse: fetch complete
//  d_ready    out  1        one-cycle pulse: data access complete
//  imemload   out  DATA_W   fetched word, valid while i_ready=1
//  dmmload    out  DATA_W   loaded word, valid while d_ready=1 (reads only)
//  bus_read   out  1        bus read strobe
//  bus_write  out  1        bus write strobe
//  bus_addr   out  ADDR_W   bus address
//  bus_wdata  out  DATA_W   bus write data
//  bus_sel    out  4        bus byte enables (4'hF for fetch)
//  bus_rdata  in   DATA_W   bus read data, valid with bus_ack
//  bus_ack    in   1        one-cycle completion pulse from the controller
//  bus_err    out  1        one-cycle pulse: transaction aborted by timeout
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0; state resets to IDLE.
//  - States and transitions:
//    - IDLE:
//      - dmmWen|dmmRen -> BUS_D.
//      - else imemRen -> BUS_I.
//      - bus_ack is ignored in IDLE.
//    - BUS_I / BUS_D: strobe, addr, wdata and sel are latched on entry and held stable until bus_ack.
//      - BUS_I drives bus_read with bus_sel=4'hF.
//      - BUS_D drives bus_write if dmmWen, else bus_read.
//      - On bus_ack -> DONE_x: the strobe is dropped and bus_rdata is registered into imemload or dmmload.
//    - DONE_I / DONE_D: i_ready or d_ready is 1 for exactly this one cycle, then IDLE.
//      - This extra cycle prevents re-issuing a request the requester is still holding.
//  - Latency: request seen in IDLE at cycle n -> strobe at n+1; bus_ack at m -> ready at m+1.
//    - Minimum 3 cycles request-to-ready; back-to-back throughput is one access per 3 cycles.
//  - Simultaneous dmmRen and dmmWen: treated as a write.
//  - Simultaneous data and fetch requests: data is granted, and fetch is granted in the next IDLE.
//    - Fetch can starve under continuous data traffic; this is accepted because the pipeline stalls fetch.
//  - Requests that drop while in BUS_x do not cancel the bus transaction; ready is still pulsed.
//  - Load data registers hold their last value until the next completion.
//  - Reset mid-transaction: asynchronous clear to IDLE with all strobes 0; a late bus_ack is ignored.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//  - An 8..16-bit counter clears on entry to BUS_x and counts each cycle without bus_ack.
//  - When the count reaches TIMEOUT_CYC:
//    - the strobe drops and the state moves to DONE_x;
//    - bus_err pulses together with ready;
//    - load data = 32'hDEADBEEF.
//  MEM_ARB_TIMEOUT_EN undefined: the arbiter waits indefinitely for bus_ack, and bus_err is tied 0.
// STRUCTURE
//  cpu_pkg:
//  - word_t;
//  - typedef enum logic [2:0] arb_state_t {IDLE, BUS_I, BUS_D, DONE_I, DONE_D};
//  - localparam ARB_ABORT_DATA = 32'hDEADBEEF.
//  Sub-module: none. The FSM, latch registers and timeout counter live in one file.
// TESTING
//  1. Fetch only: imemRen=1, imemaddr=0x100, ack 2 cycles later with rdata=0x00500093.
//     -> one bus_read with addr 0x100, sel F; i_ready pulses once; imemload=0x00500093.
//  2. Store: dmmWen=1, addr=0x2000, store=0xCAFEF00D, sel=4'b0011.
//     -> bus_write with those values held until ack; d_ready pulses once; no bus_read.
//  3. Contention: imemRen and dmmRen asserted in the same cycle.
//     -> data transaction first; fetch strobe starts 3 cycles after the data ack; exactly one ready each.
//  4. Held request: requester keeps imemRen high one cycle past i_ready.
//     -> no second bus_read issued from DONE_I.
//  5. Reset: nRst low while in BUS_D, then ack arrives after release.
//     -> all outputs 0 immediately; ack ignored; no ready pulse.
//  6. Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): read with no ack.
//     -> strobe drops after 8 cycles; d_ready=bus_err=1 for one cycle; dmmload=0xDEADBEEF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory arbiter.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    StIdle,
    StBusI,
    StBusD,
    StDoneI,
    StDoneD
  } arb_state_t;

  localparam word_t ARB_ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request-side and memory-bus signals of the arbiter; master = arbiter, slave = environment.
interface memory_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              imemRen;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmmRen;
  logic              dmmWen;
  logic [ADDR_W-1:0] dmmaddr;
  logic [DATA_W-1:0] dmmstore;
  logic [3:0]        dmmsel;
  logic              i_ready;
  logic              d_ready;
  logic [DATA_W-1:0] imemload;
  logic [DATA_W-1:0] dmmload;
  logic              bus_read;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_sel;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, dmmsel,
    input  bus_rdata, bus_ack,
    output i_ready, d_ready, imemload, dmmload,
    output bus_read, bus_write, bus_addr, bus_wdata, bus_sel, bus_err
  );

  modport slave (
    output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, dmmsel,
    output bus_rdata, bus_ack,
    input  i_ready, d_ready, imemload, dmmload,
    input  bus_read, bus_write, bus_addr, bus_wdata, bus_sel, bus_err
  );

endinterface

// File: rtl/memory_arbiter.sv
// Serialises fetch and data accesses onto one memory bus, data first, one transaction at a time.
// Optional bus timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module memory_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                nRst,
  memory_arbiter_if.master    arb
);

  arb_state_t        state_q, state_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic              bus_err_q, bus_err_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] imemload_q, imemload_d;
  logic [DATA_W-1:0] dmmload_q, dmmload_d;
  logic [DATA_W-1:0] load_data;
  logic              timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // An abort completes the transaction like an ack, but with poison data.
  assign load_data = arb.bus_ack ? arb.bus_rdata : DATA_W'(ARB_ABORT_DATA);

  always_comb begin
    state_d     = state_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    imemload_d  = imemload_q;
    dmmload_d   = dmmload_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (arb.dmmWen || arb.dmmRen) begin
          state_d     = StBusD;
          bus_write_d = arb.dmmWen;
          bus_read_d  = ~arb.dmmWen;
          bus_addr_d  = arb.dmmaddr;
          bus_wdata_d = arb.dmmstore;
          bus_sel_d   = arb.dmmsel;
        end else if (arb.imemRen) begin
          state_d     = StBusI;
          bus_write_d = 1'b0;
          bus_read_d  = 1'b1;
          bus_addr_d  = arb.imemaddr;
          bus_wdata_d = '0;
          bus_sel_d   = 4'hF;
        end
      end
      StBusI, StBusD: begin
        if (arb.bus_ack || timeout) begin
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          bus_err_d   = ~arb.bus_ack;
          if (state_q == StBusI) begin
            state_d    = StDoneI;
            i_ready_d  = 1'b1;
            imemload_d = load_data;
          end else begin
            state_d   = StDoneD;
            d_ready_d = 1'b1;
            dmmload_d = load_data;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      // Extra cycle so a requester still holding its request is not re-served.
      StDoneI, StDoneD: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= StIdle;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      imemload_q  <= '0;
      dmmload_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_err_q   <= bus_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      imemload_q  <= imemload_d;
      dmmload_q   <= dmmload_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign arb.i_ready   = i_ready_q;
  assign arb.d_ready   = d_ready_q;
  assign arb.bus_read  = bus_read_q;
  assign arb.bus_write = bus_write_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.bus_sel   = bus_sel_q;
  assign arb.imemload  = imemload_q;
  assign arb.dmmload   = dmmload_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign arb.bus_err   = bus_err_q;
`else
  logic unused_bus_err;
  assign unused_bus_err = bus_err_q;
  assign arb.bus_err   = 1'b0;
`endif

endmodule
